keypad_uart_tx: RTL and testbench

//   Successor to the single-digit switch sender. Debounces the send button and encodes the
//   SW_W-bit switch value as NDIG = ceil(SW_W/4) uppercase hex ASCII digits, MSB digit first.

---
 rtl/keypad_uart_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_keypad_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_uart_tx.sv
// Keypad-to-UART sender: debounces a send button and turns the switch value into uppercase
// hex ASCII digits, MSB digit first. The characters go through a FIFO to a built-in 8N1 UART.
// Optional feature: define KEYPAD_CRLF_EN to append CR LF after the digits of each press.
module keypad_uart_tx #(
  parameter int unsigned SW_W       = 4,
  parameter int unsigned BAUD_DIV   = 10417,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw,
  input  logic            btn,
  output logic            tx,
  output logic            busy,
  output logic            fifo_full,
  output logic            dropped
);

  localparam int unsigned NDIG   = (SW_W + 3) / 4;
  localparam int unsigned CAP_W  = 4 * NDIG;
`ifdef KEYPAD_CRLF_EN
  localparam int unsigned NCHAR  = NDIG + 2;
`else
  localparam int unsigned NCHAR  = NDIG;
`endif
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned LD_W   = $clog2(NCHAR + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Button synchroniser and debounce
  logic             btn_s1_q, btn_s2_q;
  logic             deb_q, deb_d, deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press;

  // Loader
  logic [CAP_W-1:0] cap_q, cap_d;
  logic             ld_act_q, ld_act_d;
  logic [LD_W-1:0]  ld_idx_q, ld_idx_d;
  logic             dropped_q, dropped_d;
  logic             room;
  logic             wr_en;
  logic [3:0]       nib;
  logic [7:0]       wr_char;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;

  // UART
  state_e           state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             baud_end;

  // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (btn_s2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;
  assign room  = (CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(NCHAR);

  // Loader sequencing: accept or reject a press as a whole, then write one char per cycle
  always_comb begin
    cap_d     = cap_q;
    ld_act_d  = ld_act_q;
    ld_idx_d  = ld_idx_q;
    dropped_d = 1'b0;
    wr_en     = ld_act_q;
    if (ld_act_q) begin
      if (ld_idx_q == LD_W'(NCHAR - 1)) begin
        ld_act_d = 1'b0;
        ld_idx_d = '0;
      end else begin
        ld_idx_d = ld_idx_q + 1'b1;
      end
    end
    if (press) begin
      if (room) begin
        cap_d    = CAP_W'(sw);
        ld_act_d = 1'b1;
        ld_idx_d = '0;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  // Character for the current loader slot: hex digit, or CR/LF trailer
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < NDIG; k++) begin
      if (ld_idx_q == LD_W'(k)) begin
        nib = cap_q[4*(NDIG-1-k) +: 4];
      end
    end
    wr_char = (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : (8'h41 + {4'h0, nib} - 8'd10);
`ifdef KEYPAD_CRLF_EN
    if (ld_idx_q == LD_W'(NDIG)) begin
      wr_char = 8'h0D;
    end else if (ld_idx_q == LD_W'(NDIG + 1)) begin
      wr_char = 8'h0A;
    end
`endif
  end

  // FIFO pointers and occupancy; a simultaneous write and pop leaves the count unchanged
  always_comb begin
    wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  assign baud_end = (baud_q == BAUD_W'(BAUD_DIV - 1));

  // UART sequencing: every state lasts BAUD_DIV cycles; STOP chains straight into START
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = mem_q[rptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shreg_d = mem_q[rptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Serial line derived from registered state so reset forces it high at once
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shreg_q[bit_q];
      default: tx = 1'b1;
    endcase
  end

  assign busy      = (count_q != '0) | (state_q != StIdle);
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign dropped   = dropped_q;

  // Character storage; contents are don't-care while the count says empty
  always_ff @(posedge sysclk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wr_char;
    end
  end

  // All control state
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      cap_q      <= '0;
      ld_act_q   <= 1'b0;
      ld_idx_q   <= '0;
      dropped_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'h00;
    end else begin
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      cap_q      <= cap_d;
      ld_act_q   <= ld_act_d;
      ld_idx_q   <= ld_idx_d;
      dropped_q  <= dropped_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
    end
  end

endmodule

// File: tb/tb_keypad_uart_tx.sv
// Bench for keypad_uart_tx: a timeline model of the character queue predicts, for every cycle,
// the serial line, busy, fifo_full and dropped from the press times alone.
module tb_keypad_uart_tx;

  localparam int unsigned SW_W       = 8;
  localparam int unsigned BAUD_DIV   = 4;
  localparam int unsigned DEB_CYCLES = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NDIG       = 2;
  localparam int unsigned FRAME      = 10 * BAUD_DIV;

  logic            sysclk = 1'b0;
  logic            rst_n  = 1'b0;
  logic            btn    = 1'b0;
  logic [SW_W-1:0] sw     = '0;
  logic            tx, busy, fifo_full, dropped;

  keypad_uart_tx #(
    .SW_W      (SW_W),
    .BAUD_DIV  (BAUD_DIV),
    .DEB_CYCLES(DEB_CYCLES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn      (btn),
    .tx       (tx),
    .busy     (busy),
    .fifo_full(fifo_full),
    .dropped  (dropped)
  );

  always #5 sysclk = ~sysclk;

  // Number of rising edges seen so far
  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: per queued char, its value, the edge it is written and the edge its frame starts
  byte unsigned m_ch[$];
  int unsigned  m_w[$];
  int unsigned  m_s[$];
  int unsigned  m_drop[$];

  function automatic byte unsigned hexc(input int unsigned v);
    return (v < 10) ? byte'(8'h30 + v) : byte'(8'h41 + v - 10);
  endfunction

  function automatic int occ(input int unsigned c);
    int n = 0;
    foreach (m_w[k]) if (m_w[k] <= c) n++;
    foreach (m_s[k]) if (m_s[k] <= c) n--;
    return n;
  endfunction

  function automatic logic exp_tx(input int unsigned c);
    foreach (m_s[k]) begin
      if (c >= m_s[k] && c < m_s[k] + FRAME) begin
        int unsigned  b = (c - m_s[k]) / BAUD_DIV;
        byte unsigned x = m_ch[k];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return x[b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int unsigned c);
    if (occ(c) > 0) return 1'b1;
    foreach (m_s[k]) if (c >= m_s[k] && c < m_s[k] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_drop(input int unsigned c);
    foreach (m_drop[k]) if (m_drop[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle
  always @(negedge sysclk) begin
    if (chk_en) begin
      check("tx", tx, exp_tx(cyc));
      check("busy", busy, exp_busy(cyc));
      check("fifo_full", fifo_full, (occ(cyc) == FIFO_DEPTH) ? 1'b1 : 1'b0);
      check("dropped", dropped, exp_drop(cyc));
    end
  end

  // Called at a falling edge: raise btn and enter the press outcome into the model
  task automatic do_press(input logic [SW_W-1:0] v, output int unsigned d);
    sw  = v;
    btn = 1'b1;
    d   = cyc + 2 + DEB_CYCLES;  // edge at which the debounced level rises
    if (FIFO_DEPTH - occ(d) >= NDIG) begin
      for (int i = 0; i < NDIG; i++) begin
        int unsigned w = d + 2 + i;
        int unsigned s = w + 1;
        if (m_s.size() > 0 && m_s[$] + FRAME > s) s = m_s[$] + FRAME;
        m_ch.push_back(hexc((v >> (4 * (NDIG - 1 - i))) & 4'hF));
        m_w.push_back(w);
        m_s.push_back(s);
      end
    end else begin
      m_drop.push_back(d + 1);
    end
  endtask

  task automatic release_btn(input int unsigned extra);
    repeat (DEB_CYCLES + 3 + extra) @(negedge sysclk);
    btn = 1'b0;
    repeat (DEB_CYCLES + 4) @(negedge sysclk);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge sysclk);
  endtask

  task automatic drain();
    int unsigned target = cyc + 2;
    if (m_s.size() > 0 && m_s[$] + FRAME + 2 > target) target = m_s[$] + FRAME + 2;
    wait_cyc(target);
    check("busy_drained", busy, 1'b0);
    check("tx_drained", tx, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d, d2;

    // Reset state
    repeat (3) @(negedge sysclk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_dropped", dropped, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge sysclk);

    // Single press: fixed 3-cycle latency from debounced edge to start bit
    do_press(8'h07, d);
    wait_cyc(d + 2);
    check("latency_pre", tx, 1'b1);
    wait_cyc(d + 3);
    check("latency_start", tx, 1'b0);
    release_btn(0);
    drain();

    // Two digits back to back: 'A' then '5'
    do_press(8'hA5, d);
    release_btn(2);
    drain();

    // Bouncing button, ending low, then held high: exactly one press
    for (int seg = 0; seg < 14; seg++) begin
      btn = (seg % 2 == 0);
      repeat (3) @(negedge sysclk);
    end
    do_press(8'($urandom), d);
    release_btn(1);
    drain();

    // Presses arriving faster than the line drains: fills the FIFO, then drops
    for (int i = 0; i < 4; i++) begin
      do_press(8'($urandom), d);
      release_btn(0);
    end
    drain();

    // Loader write landing on the same edge as a STOP->START pop
    do_press(8'h3C, d);
    release_btn(0);
    wait_cyc(d + FRAME + 3 - DEB_CYCLES - 4);
    do_press(8'hE9, d2);
    release_btn(0);
    drain();

    // Random values and spacing
    for (int i = 0; i < 14; i++) begin
      do_press(8'($urandom), d);
      release_btn($urandom_range(0, 4));
      repeat ($urandom_range(0, 40)) @(negedge sysclk);
    end
    drain();

    // Reset during data bit 3 aborts the frame immediately
    do_press(8'($urandom), d);
    repeat (DEB_CYCLES + 3) @(negedge sysclk);
    btn = 1'b0;
    wait_cyc(d + 3 + 4 * BAUD_DIV + 1);
    check("pre_reset_busy", busy, 1'b1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_full", fifo_full, 1'b0);
    m_ch.delete();
    m_w.delete();
    m_s.delete();
    m_drop.delete();
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk_en = 1'b1;
    repeat (FRAME + 5) @(negedge sysclk);

    // Normal operation after reset
    do_press(8'($urandom), d);
    release_btn(0);
    drain();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
